// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned OFFSET_W    = $clog2(WORD_BYTES);

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 single-port word array: synchronous write, combinational read.
module dmem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset; contents must survive reset, and a reset loop would prevent RAM mapping.
  always_ff @(posedge clock) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one load/store in IDLE, stalls the
// pipeline while the access is in flight, and pulses op_ready after LATENCY cycles.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ip_read_en,
  input  logic        ip_write_en,
  input  logic [31:0] ip_addr,
  input  logic [31:0] ip_data,
  output logic [31:0] op_data,
  output logic        op_ready,
  output logic        op_busy,
  output logic        op_err
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("dmem_responder: LATENCY %0d outside 1..%0d", LATENCY, MAX_LATENCY);
  end
  if (LATENCY - 1 >= 2 ** CNT_W) begin : g_bad_cnt_w
    $error("dmem_responder: CNT_W %0d too narrow for LATENCY %0d", CNT_W, LATENCY);
  end

  // WAIT lasts LATENCY-1 cycles, so the counter starts at LATENCY-2 and exits on zero.
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  dmem_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              req_we;
  logic              req_err;
  logic [ADDR_W-1:0] req_idx;
  logic [31:0]       req_wdata;

  logic              req_present;
  logic              ip_err;
  logic [ADDR_W-1:0] ip_idx;
  logic [ADDR_W-1:0] ram_idx;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic              unused_addr_bits;

  assign req_present = ip_read_en | ip_write_en;
  assign ip_idx      = ip_addr[ADDR_W+OFFSET_W-1:OFFSET_W];
  assign ip_err      = (ip_addr[OFFSET_W-1:0] != '0) || (ip_read_en && ip_write_en);

  // Upper address bits are intentionally dropped so accesses wrap modulo DEPTH.
  assign unused_addr_bits = ^ip_addr[31:ADDR_W+OFFSET_W];

  // In IDLE the port looks at the live address so a LATENCY==1 read can load on the accept edge.
  assign ram_idx = (state == IDLE) ? ip_idx : req_idx;
  assign ram_we  = (state == RESP) && req_we && !req_err && !reset;

  assign op_busy = ((state == IDLE) && req_present) || (state == WAIT);

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: all state here is sequential and uses <= so every branch sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_we    <= 1'b0;
      req_err   <= 1'b0;
      req_idx   <= '0;
      req_wdata <= '0;
      op_data   <= '0;
      op_ready  <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      op_ready <= 1'b0;
      op_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_present) begin
            req_we    <= ip_write_en;
            req_idx   <= ip_idx;
            req_wdata <= ip_data;
            req_err   <= ip_err;
            if (LATENCY == 1) begin
              state    <= RESP;
              op_ready <= 1'b1;
              op_err   <= ip_err;
              if (!ip_write_en && !ip_err) op_data <= ram_rdata;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state    <= RESP;
            op_ready <= 1'b1;
            op_err   <= req_err;
            if (!req_we && !req_err) op_data <= ram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench: a LATENCY=3 and a LATENCY=1 responder side by side.
module tb_dmem_responder;

  logic        clock;
  logic        reset;

  logic        rd3, wr3, rd1, wr1;
  logic [31:0] addr3, wdata3, addr1, wdata1;
  logic [31:0] data3, data1;
  logic        ready3, busy3, err3;
  logic        ready1, busy1, err1;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [2][256];
  logic [31:0] last_rd [2];
  int          checks = 0;
  int          errors = 0;

  dmem_responder #(.ADDR_W(8), .LATENCY(3), .CNT_W(4)) dut3 (
    .clock       (clock),
    .reset       (reset),
    .ip_read_en  (rd3),
    .ip_write_en (wr3),
    .ip_addr     (addr3),
    .ip_data     (wdata3),
    .op_data     (data3),
    .op_ready    (ready3),
    .op_busy     (busy3),
    .op_err      (err3)
  );

  dmem_responder #(.ADDR_W(8), .LATENCY(1), .CNT_W(4)) dut1 (
    .clock       (clock),
    .reset       (reset),
    .ip_read_en  (rd1),
    .ip_write_en (wr1),
    .ip_addr     (addr1),
    .ip_data     (wdata1),
    .op_data     (data1),
    .op_ready    (ready1),
    .op_busy     (busy1),
    .op_err      (err1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    @(negedge clock);
    rd3 = 1'b0; wr3 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
  endtask

  // One request on the selected DUT; the expected result is queued at drive time.
  task automatic req(input bit l1, input bit rd, input bit wr,
                     input logic [31:0] addr, input logic [31:0] wd);
    int          lat;
    int          n;
    int          d;
    bit          seen;
    logic [7:0]  idx;
    exp_t        e;
    exp_t        got;
    lat  = l1 ? 1 : 3;
    d    = l1 ? 1 : 0;
    idx  = addr[9:2];
    e.err = (addr[1:0] != 2'b00) || (rd && wr);
    if (!e.err && wr)  model[d][idx] = wd;
    if (!e.err && !wr) last_rd[d] = model[d][idx];
    e.data = last_rd[d];
    sbq.push_back(e);

    @(negedge clock);
    if (l1) begin rd1 = rd; wr1 = wr; addr1 = addr; wdata1 = wd; end
    else    begin rd3 = rd; wr3 = wr; addr3 = addr; wdata3 = wd; end
    #1;
    chk("busy_accept", l1 ? busy1 : busy3, 1);
    chk("ready_accept", l1 ? ready1 : ready3, 0);

    seen = 0;
    n    = 0;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      if (l1 ? ready1 : ready3) seen = 1;
      else chk("busy_wait", l1 ? busy1 : busy3, 1);
    end
    chk("latency", n, lat);
    if (seen) begin
      chk("sb_nonempty", sbq.size(), 1);
      if (sbq.size() > 0) begin
        got = sbq.pop_front();
        chk("data", l1 ? data1 : data3, got.data);
        chk("err", l1 ? err1 : err3, got.err);
        chk("busy_resp", l1 ? busy1 : busy3, 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    rd3 = 0; wr3 = 0; addr3 = 0; wdata3 = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_data3", data3, 0);
    chk("rst_ready3", ready3, 0);
    chk("rst_err3", err3, 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_data1", data1, 0);
    chk("rst_ready1", ready1, 0);

    // Write then read back.
    req(0, 0, 1, 32'h10, 32'hDEADBEEF);
    req(0, 1, 0, 32'h10, 32'h0);
    // Misaligned read: error, data held, mem[4] untouched.
    req(0, 1, 0, 32'h13, 32'h0);
    req(0, 1, 0, 32'h10, 32'h0);
    // Both enables: error, no write to mem[8].
    req(0, 0, 1, 32'h20, 32'h0BADF00D);
    req(0, 1, 1, 32'h20, 32'hFFFFFFFF);
    req(0, 1, 0, 32'h20, 32'h0);
    // Address wrap to word 0.
    req(0, 0, 1, 32'h400, 32'h12345678);
    req(0, 1, 0, 32'h000, 32'h0);
    // Prior contents for the aborted-write location.
    req(0, 0, 1, 32'h30, 32'h11110000);

    // Write aborted by reset one cycle after accept.
    @(negedge clock);
    rd3 = 0; wr3 = 1; addr3 = 32'h30; wdata3 = 32'hAAAA5555;
    #1 chk("abort_busy", busy3, 1);
    @(negedge clock);
    reset = 1'b1;
    wr3   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    #1;
    chk("abort_busy_after", busy3, 0);
    chk("abort_ready_after", ready3, 0);
    chk("abort_data_cleared", data3, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("abort_no_ready", ready3, 0);
    end
    req(0, 1, 0, 32'h30, 32'h0);
    idle_inputs();

    // LATENCY=1: back-to-back traffic, busy only in accept cycles.
    req(1, 0, 1, 32'h0, 32'hCAFE0000);
    req(1, 0, 1, 32'h4, 32'hCAFE0004);
    req(1, 1, 0, 32'h0, 32'h0);
    req(1, 1, 0, 32'h4, 32'h0);
    req(1, 1, 0, 32'h6, 32'h0);
    idle_inputs();
    #1 chk("l1_idle_busy", busy1, 0);
    @(negedge clock);
    chk("l1_idle_ready", ready1, 0);
    chk("l1_data_hold", data1, 32'hCAFE0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
